intr_vec_rx: RTL and testbench
==============================

Name: intr_vec_rx

Overview:
- Receiving end of the interrupt-vector pulse protocol. A sender raises intr_vec_req together with intr_num, holds both for INTR_CYCLES cycles, then drops both for at least INTR_CYCLES cycles.
- This block captures each pulse as one event and keeps a per-vector pending bitmap with a mask.
- Unmasked new events go into a small vector FIFO. Software or a downstream CPU-side agent pops the FIFO over a valid/ready handshake and clears pending bits.

Parameters:
- PORTS, 32, number of interrupt vectors; intr_num width NW = $clog2(PORTS).
- INTR_CYCLES, 2, nominal pulse high/low length of the sender; used only by the optional checker.
- FIFO_DEPTH, 8, vector FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- intr_vec_req  in  1  sender request pulse.
- intr_num  in  NW  vector number; valid while intr_vec_req=1.
- mask  in  PORTS  1 = vector masked. A masked vector still sets its pending bit, but is not enqueued and does not raise irq.
- clr_valid  in  1  clear strobe.
- clr_num  in  NW  pending bit to clear.
- vec_valid  out  1  FIFO head valid.
- vec_num  out  NW  FIFO head vector.
- vec_ready  in  1  pop head when vec_valid & vec_ready.
- pending  out  PORTS  registered pending bitmap.
- irq  out  1  registered; irq = |(pending & ~mask), one cycle after the pending/mask change.
- overflow  out  1  sticky; cleared only by rst.
- proto_err  out  1  sticky protocol-error flag; tied 0 when the optional feature is absent.

Behaviour:
- Reset values: vec_valid=0, vec_num=0, pending=0, irq=0, overflow=0, proto_err=0; FIFO empty; FSM in RX_WAIT_LOW.
- Receive FSM states:
  - RX_WAIT_LOW: stay until intr_vec_req=0, then go to RX_IDLE. Entered after reset, so a pulse already in progress at reset release is never captured.
  - RX_IDLE: at a clock edge where intr_vec_req=1, capture intr_num as event E and go to RX_HIGH.
  - RX_HIGH: wait for intr_vec_req=0, then go to RX_IDLE.
- Exactly one event per pulse, regardless of how long the pulse lasts.
- Event E processing, at the same edge where E is captured:
  - If intr_num ≥ PORTS: ignore E.
  - Otherwise, if pending[E]=1 (coalesced): no enqueue.
  - Otherwise set pending[E]. If mask[E]=0, push E into the FIFO.
- Push latency: E captured at edge k → pending[E]=1 and, if the FIFO was empty, vec_valid=1 with vec_num=E after edge k. irq follows after edge k+1.
- FIFO full on push:
  - If a pop happens in the same cycle, the push succeeds.
  - Otherwise E is dropped from the FIFO (pending[E] is still set) and overflow is set.
- FIFO is first-word-fall-through: vec_num is stable while vec_valid=1 and vec_ready=0. Pops from an empty FIFO are ignored.
- Clear: clr_valid=1 clears pending[clr_num] at the next edge. Out-of-range clr_num is ignored.
- Clear and set of the same vector in the same cycle: set wins.
- FIFO entries are not removed by a clear. Software pops them and sees stale vectors, which is acceptable.
- A mask change does not retro-enqueue vectors that are already pending.
- rst during any state returns to reset values in one cycle; the FIFO contents are discarded.

Optional Feature:
- Macro: INTR_VEC_RX_PROTO_CHECK_EN.
- Present:
  - An 8-bit counter measures the length of each high phase and each low phase.
  - proto_err is set if a high phase length ≠ INTR_CYCLES, or a low phase between two pulses is < INTR_CYCLES.
  - proto_err is also set if intr_num changes while intr_vec_req=1.
  - Events are still captured normally.
- Absent: no counter logic; proto_err is a constant 0.

Decomposition:
- Shared package/header intr_pkg:
  - receive FSM state encoding (RX_WAIT_LOW, RX_IDLE, RX_HIGH; 2 bits);
  - a function computing NW from PORTS;
  - default INTR_CYCLES, shared with the sender.
- One sub-module: intr_vec_fifo.
  - Synchronous FWFT FIFO, parameters WIDTH and DEPTH.
  - Ports: push, push_data, pop, full, empty, head.
  - Registered read pointer and write pointer, plus an extra wrap bit.

Test Plan:
- Reset with intr_vec_req held at 1 through rst release, num=5 → no event. Then drop req, pulse num=5 → pending=0x20, vec_valid=1, vec_num=5, irq=1 one cycle later.
- Pulses 3, 3, 7 with the FIFO not popped → pending=0x88, FIFO holds {3,7}. Second 3 coalesced, overflow=0.
- mask[9]=1, pulse 9 → pending[9]=1, vec_valid=0, irq=0. Clear mask → irq=1 next cycle, still no FIFO entry.
- FIFO_DEPTH=8: 9 distinct pulses 0..8 without pops → 8 entries 0..7, pending=0x1FF, overflow=1. Pop all → order 0..7.
- clr_valid with clr_num=4 in the same cycle a pulse with num=4 is captured → pending[4]=1 afterwards. Clear again → pending[4]=0, irq=0.
- Macro on, INTR_CYCLES=2: high pulse of 3 cycles → proto_err=1. Macro off, same stimulus → proto_err=0, event captured.

Source files
------------

// File: rtl/intr_pkg.sv
// intr_pkg: shared receive-FSM encoding, width helper and protocol
// defaults for the interrupt-vector pulse protocol (sender and receiver).
package intr_pkg;

    localparam int INTR_CYCLES_DEF = 2;
    localparam int PORTS_DEF       = 32;
    localparam int FIFO_DEPTH_DEF  = 8;

    typedef enum logic [1:0] {
        RX_WAIT_LOW = 2'd0,
        RX_IDLE     = 2'd1,
        RX_HIGH     = 2'd2
    } rx_state_e;

    function automatic int nw_of(input int ports);
        return (ports > 1) ? $clog2(ports) : 1;
    endfunction

endpackage

// File: rtl/intr_vec_rx_if.sv
// intr_vec_rx_if: pulse input, mask, clear strobe, vector pop handshake
// and status bundle of the interrupt-vector receiver.
interface intr_vec_rx_if
    import intr_pkg::*;
#(
    parameter int PORTS = PORTS_DEF
);
    localparam int NW = nw_of(PORTS);

    logic             intr_vec_req;
    logic [NW-1:0]    intr_num;
    logic [PORTS-1:0] mask;
    logic             clr_valid;
    logic [NW-1:0]    clr_num;
    logic             vec_valid;
    logic [NW-1:0]    vec_num;
    logic             vec_ready;
    logic [PORTS-1:0] pending;
    logic             irq;
    logic             overflow;
    logic             proto_err;

    modport master (
        output intr_vec_req, intr_num, mask,
        output clr_valid, clr_num, vec_ready,
        input  vec_valid, vec_num, pending,
        input  irq, overflow, proto_err
    );

    modport slave (
        input  intr_vec_req, intr_num, mask,
        input  clr_valid, clr_num, vec_ready,
        output vec_valid, vec_num, pending,
        output irq, overflow, proto_err
    );

endinterface

// File: rtl/intr_vec_fifo.sv
// intr_vec_fifo: synchronous first-word-fall-through FIFO with
// wrap-bit pointers; a push into a full FIFO lands if a pop happens too.
module intr_vec_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      wr_ptr_d;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW])
                && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: empty gates every read of it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/intr_vec_rx.sv
// intr_vec_rx: interrupt-vector pulse receiver with pending bitmap, mask
// and vector FIFO. Define INTR_VEC_RX_PROTO_CHECK_EN for pulse timing checks.
module intr_vec_rx
    import intr_pkg::*;
#(
    parameter int PORTS       = PORTS_DEF,
    parameter int INTR_CYCLES = INTR_CYCLES_DEF,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
    input logic          clk,
    input logic          rst,
    intr_vec_rx_if.slave bus
);
    localparam int NW = nw_of(PORTS);

    generate
        if (FIFO_DEPTH < 2
            || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0
            || INTR_CYCLES < 1
            || INTR_CYCLES > 255) begin : g_bad_cfg
            $error("intr_vec_rx: bad FIFO_DEPTH or INTR_CYCLES");
        end
    endgenerate

    rx_state_e        state_q;
    logic [PORTS-1:0] pending_q;
    logic [PORTS-1:0] pending_d;
    logic             irq_q;
    logic             overflow_q;

    logic             capture;
    logic             evt_in_range;
    logic             evt_hit;
    logic             evt_new;
    logic             evt_push;
    logic             clr_hit;
    logic             pop_fire;
    logic             drop;

    logic             fifo_full;
    logic             fifo_empty;
    logic [NW-1:0]    fifo_head;

    // One event per pulse: only the IDLE->HIGH edge captures.
    assign capture      = (state_q == RX_IDLE) && bus.intr_vec_req;
    assign evt_in_range = 32'(bus.intr_num) < PORTS;
    assign evt_hit      = capture && evt_in_range;
    assign evt_new      = evt_hit && !pending_q[bus.intr_num];
    assign evt_push     = evt_new && !bus.mask[bus.intr_num];
    assign clr_hit      = bus.clr_valid
                       && (32'(bus.clr_num) < PORTS);

    assign pop_fire = bus.vec_ready && !fifo_empty;
    assign drop     = evt_push && fifo_full && !pop_fire;

    always_comb begin
        pending_d = pending_q;
        if (clr_hit) begin
            pending_d[bus.clr_num] = 1'b0;
        end
        if (evt_hit) begin
            pending_d[bus.intr_num] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RX_WAIT_LOW;
            pending_q  <= '0;
            irq_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            unique case (state_q)
                RX_WAIT_LOW: begin
                    if (!bus.intr_vec_req) state_q <= RX_IDLE;
                end
                RX_IDLE: begin
                    if (bus.intr_vec_req) state_q <= RX_HIGH;
                end
                RX_HIGH: begin
                    if (!bus.intr_vec_req) state_q <= RX_IDLE;
                end
                default: state_q <= RX_WAIT_LOW;
            endcase
            pending_q <= pending_d;
            irq_q     <= |(pending_q & ~bus.mask);
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    intr_vec_fifo #(
        .WIDTH (NW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (evt_push),
        .push_data (bus.intr_num),
        .pop       (bus.vec_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign bus.vec_valid = !fifo_empty;
    assign bus.vec_num   = fifo_empty ? '0 : fifo_head;
    assign bus.pending   = pending_q;
    assign bus.irq       = irq_q;
    assign bus.overflow  = overflow_q;

`ifdef INTR_VEC_RX_PROTO_CHECK_EN
    logic [7:0]    cnt_q;
    logic          prev_req_q;
    logic [NW-1:0] prev_num_q;
    logic          armed_q;
    logic          high_armed_q;
    logic          had_pulse_q;
    logic          proto_err_q;
    logic          rise;
    logic          fall;
    logic          err_now;

    assign rise = bus.intr_vec_req && !prev_req_q;
    assign fall = !bus.intr_vec_req && prev_req_q;

    // Phases cut short by reset are not judged: a high phase counts only
    // if low was seen first, a low phase only after a judged pulse.
    always_comb begin
        err_now = 1'b0;
        if (fall && high_armed_q
            && cnt_q != 8'(INTR_CYCLES)) begin
            err_now = 1'b1;
        end
        if (rise && had_pulse_q
            && cnt_q < 8'(INTR_CYCLES)) begin
            err_now = 1'b1;
        end
        if (bus.intr_vec_req && prev_req_q
            && bus.intr_num != prev_num_q) begin
            err_now = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            prev_req_q   <= 1'b0;
            prev_num_q   <= '0;
            armed_q      <= 1'b0;
            high_armed_q <= 1'b0;
            had_pulse_q  <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            prev_req_q <= bus.intr_vec_req;
            prev_num_q <= bus.intr_num;
            armed_q    <= armed_q || !bus.intr_vec_req;
            if (rise) begin
                high_armed_q <= armed_q;
            end
            if (fall) begin
                had_pulse_q <= had_pulse_q || high_armed_q;
            end
            if (rise || fall) begin
                cnt_q <= 8'd1;
            end else if (cnt_q != 8'hFF) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (err_now) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    assign bus.proto_err = proto_err_q;
`else
    assign bus.proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_intr_vec_rx.sv
// tb_intr_vec_rx: directed checks of pulse capture, coalescing, mask,
// FIFO overflow/order, clear-vs-set and the optional protocol checker.
module tb_intr_vec_rx;
    import intr_pkg::*;

    localparam int PORTS = 32;
    localparam int NW    = 5;

`ifdef INTR_VEC_RX_PROTO_CHECK_EN
    localparam logic PROTO_EXP = 1'b1;
`else
    localparam logic PROTO_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    intr_vec_rx_if #(.PORTS(PORTS)) bus ();

    intr_vec_rx #(
        .PORTS       (PORTS),
        .INTR_CYCLES (2),
        .FIFO_DEPTH  (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.intr_vec_req = 1'b0;
        bus.intr_num     = '0;
        bus.mask         = '0;
        bus.clr_valid    = 1'b0;
        bus.clr_num      = '0;
        bus.vec_ready    = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic pulse(input logic [NW-1:0] n, input int hi);
        bus.intr_vec_req = 1'b1;
        bus.intr_num     = n;
        repeat (hi) tick();
        bus.intr_vec_req = 1'b0;
        bus.intr_num     = '0;
        repeat (2) tick();
    endtask

    task automatic pop_one();
        bus.vec_ready = 1'b1;
        tick();
        bus.vec_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        bus.intr_vec_req = 1'b1;
        bus.intr_num     = 5'd5;
        tick();
        tick();
        n_vec++;
        if (bus.vec_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_valid got %b want 0", bus.vec_valid);
        end
        n_vec++;
        if (bus.vec_num !== 5'd0) begin
            n_err++;
            $display("FAIL rst_num got %0d want 0", bus.vec_num);
        end
        n_vec++;
        if (bus.pending !== 32'h0) begin
            n_err++;
            $display("FAIL rst_pend got %h want 0", bus.pending);
        end
        n_vec++;
        if ({bus.irq, bus.overflow, bus.proto_err} !== 3'b000) begin
            n_err++;
            $display("FAIL rst_flags got %b%b%b want 000",
                     bus.irq, bus.overflow, bus.proto_err);
        end
        rst = 1'b0;
        repeat (3) tick();
        n_vec++;
        if (bus.pending !== 32'h0 || bus.vec_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_held_pulse got pend %h valid %b want 0 0",
                     bus.pending, bus.vec_valid);
        end
        bus.intr_vec_req = 1'b0;
        bus.intr_num     = '0;
        repeat (2) tick();
        bus.intr_vec_req = 1'b1;
        bus.intr_num     = 5'd5;
        tick();
        n_vec++;
        if (bus.pending !== 32'h20) begin
            n_err++;
            $display("FAIL first_pend got %h want 20", bus.pending);
        end
        n_vec++;
        if (bus.vec_valid !== 1'b1 || bus.vec_num !== 5'd5) begin
            n_err++;
            $display("FAIL first_head got %b/%0d want 1/5",
                     bus.vec_valid, bus.vec_num);
        end
        n_vec++;
        if (bus.irq !== 1'b0) begin
            n_err++;
            $display("FAIL first_irq_early got %b want 0", bus.irq);
        end
        tick();
        n_vec++;
        if (bus.irq !== 1'b1) begin
            n_err++;
            $display("FAIL first_irq got %b want 1", bus.irq);
        end
        bus.intr_vec_req = 1'b0;
        bus.intr_num     = '0;
        repeat (2) tick();
        n_vec++;
        if (bus.proto_err !== 1'b0) begin
            n_err++;
            $display("FAIL good_pulse_perr got %b want 0", bus.proto_err);
        end
    endtask

    task automatic test_coalesce();
        do_reset();
        pulse(5'd3, 2);
        pulse(5'd3, 2);
        pulse(5'd7, 2);
        n_vec++;
        if (bus.pending !== 32'h88) begin
            n_err++;
            $display("FAIL coal_pend got %h want 88", bus.pending);
        end
        n_vec++;
        if (bus.vec_valid !== 1'b1 || bus.vec_num !== 5'd3) begin
            n_err++;
            $display("FAIL coal_head got %b/%0d want 1/3",
                     bus.vec_valid, bus.vec_num);
        end
        n_vec++;
        if (bus.overflow !== 1'b0 || bus.proto_err !== 1'b0) begin
            n_err++;
            $display("FAIL coal_flags got ovf %b perr %b want 0 0",
                     bus.overflow, bus.proto_err);
        end
        pop_one();
        n_vec++;
        if (bus.vec_valid !== 1'b1 || bus.vec_num !== 5'd7) begin
            n_err++;
            $display("FAIL coal_second got %b/%0d want 1/7",
                     bus.vec_valid, bus.vec_num);
        end
        pop_one();
        n_vec++;
        if (bus.vec_valid !== 1'b0) begin
            n_err++;
            $display("FAIL coal_empty got %b want 0", bus.vec_valid);
        end
    endtask

    task automatic test_mask();
        do_reset();
        bus.mask = 32'h200;
        pulse(5'd9, 2);
        n_vec++;
        if (bus.pending !== 32'h200) begin
            n_err++;
            $display("FAIL mask_pend got %h want 200", bus.pending);
        end
        n_vec++;
        if (bus.vec_valid !== 1'b0 || bus.irq !== 1'b0) begin
            n_err++;
            $display("FAIL mask_quiet got valid %b irq %b want 0 0",
                     bus.vec_valid, bus.irq);
        end
        bus.mask = '0;
        tick();
        n_vec++;
        if (bus.irq !== 1'b1) begin
            n_err++;
            $display("FAIL unmask_irq got %b want 1", bus.irq);
        end
        n_vec++;
        if (bus.vec_valid !== 1'b0) begin
            n_err++;
            $display("FAIL unmask_noenq got %b want 0", bus.vec_valid);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 8; i++) pulse(NW'(i), 2);
        n_vec++;
        if (bus.overflow !== 1'b0 || bus.pending !== 32'hFF) begin
            n_err++;
            $display("FAIL full_no_ovf got ovf %b pend %h want 0 ff",
                     bus.overflow, bus.pending);
        end
        pulse(5'd8, 2);
        n_vec++;
        if (bus.pending !== 32'h1FF) begin
            n_err++;
            $display("FAIL ovf_pend got %h want 1ff", bus.pending);
        end
        n_vec++;
        if (bus.overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_flag got %b want 1", bus.overflow);
        end
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (bus.vec_valid !== 1'b1 || bus.vec_num !== NW'(i)) begin
                n_err++;
                $display("FAIL ovf_order[%0d] got %b/%0d want 1/%0d",
                         i, bus.vec_valid, bus.vec_num, i);
            end
            pop_one();
        end
        n_vec++;
        if (bus.vec_valid !== 1'b0 || bus.overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_drain got valid %b ovf %b want 0 1",
                     bus.vec_valid, bus.overflow);
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int i = 0; i < 8; i++) pulse(NW'(i), 2);
        bus.intr_vec_req = 1'b1;
        bus.intr_num     = 5'd8;
        bus.vec_ready    = 1'b1;
        tick();
        bus.vec_ready    = 1'b0;
        tick();
        bus.intr_vec_req = 1'b0;
        bus.intr_num     = '0;
        repeat (2) tick();
        n_vec++;
        if (bus.overflow !== 1'b0 || bus.pending !== 32'h1FF) begin
            n_err++;
            $display("FAIL fullpop got ovf %b pend %h want 0 1ff",
                     bus.overflow, bus.pending);
        end
        for (int i = 1; i < 9; i++) begin
            n_vec++;
            if (bus.vec_valid !== 1'b1 || bus.vec_num !== NW'(i)) begin
                n_err++;
                $display("FAIL fullpop_order[%0d] got %b/%0d want 1/%0d",
                         i, bus.vec_valid, bus.vec_num, i);
            end
            pop_one();
        end
        n_vec++;
        if (bus.vec_valid !== 1'b0) begin
            n_err++;
            $display("FAIL fullpop_empty got %b want 0", bus.vec_valid);
        end
    endtask

    task automatic test_clear();
        do_reset();
        bus.intr_vec_req = 1'b1;
        bus.intr_num     = 5'd4;
        bus.clr_valid    = 1'b1;
        bus.clr_num      = 5'd4;
        tick();
        bus.clr_valid    = 1'b0;
        n_vec++;
        if (bus.pending !== 32'h10) begin
            n_err++;
            $display("FAIL set_wins got %h want 10", bus.pending);
        end
        tick();
        bus.intr_vec_req = 1'b0;
        bus.intr_num     = '0;
        repeat (2) tick();
        pop_one();
        n_vec++;
        if (bus.irq !== 1'b1) begin
            n_err++;
            $display("FAIL clr_pre_irq got %b want 1", bus.irq);
        end
        bus.clr_valid = 1'b1;
        bus.clr_num   = 5'd4;
        tick();
        bus.clr_valid = 1'b0;
        n_vec++;
        if (bus.pending !== 32'h0) begin
            n_err++;
            $display("FAIL clr_pend got %h want 0", bus.pending);
        end
        tick();
        n_vec++;
        if (bus.irq !== 1'b0) begin
            n_err++;
            $display("FAIL clr_irq got %b want 0", bus.irq);
        end
    endtask

    task automatic test_proto();
        do_reset();
        pulse(5'd11, 3);
        n_vec++;
        if (bus.pending !== 32'h800) begin
            n_err++;
            $display("FAIL long_pend got %h want 800", bus.pending);
        end
        n_vec++;
        if (bus.vec_valid !== 1'b1 || bus.vec_num !== 5'd11) begin
            n_err++;
            $display("FAIL long_head got %b/%0d want 1/11",
                     bus.vec_valid, bus.vec_num);
        end
        n_vec++;
        if (bus.proto_err !== PROTO_EXP) begin
            n_err++;
            $display("FAIL long_perr got %b want %b",
                     bus.proto_err, PROTO_EXP);
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_coalesce();
        test_mask();
        test_overflow();
        test_full_pop();
        test_clear();
        test_proto();
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
